// File: rtl/if_id_queue.sv
// if_id_queue
// DEPTH-entry FIFO of (pc, inst) pairs sitting between instruction fetch and
// decode, followed by a registered output stage that feeds ID.  An empty,
// unstalled queue forwards a push straight into the output stage, so the
// latency matches the old single-register IF/ID stage.  A flush discards the
// queue and the output stage.  With nothing to hand out, ID sees a bubble
// (pc 0, inst 0, valid 0).
//
// Ports
//   clk_in     clock, all state updates on posedge
//   rst_in     asynchronous active-low reset
//   rdy_in     global ready; 0 freezes every register
//   flush_in   jump/branch taken: clear queue and output stage
//   stall_in   ID stalled: output stage holds, pushes may still queue
//   instE_in   IF presents a valid instruction
//   pc_in      pc of pushed instruction
//   inst_in    pushed instruction
//   full_out   count == DEPTH (combinational from count only)
//   count_out  queue occupancy, output stage not included
//   pc_out     registered pc to ID
//   inst_out   registered instruction to ID
//   valid_out  registered; pc_out/inst_out carry a real instruction
module if_id_queue #(
   parameter int ADDR_WIDTH = 32,
   parameter int INST_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int PTR_WIDTH  = 2
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic                  flush_in,
   input  logic                  stall_in,
   input  logic                  instE_in,
   input  logic [ADDR_WIDTH-1:0] pc_in,
   input  logic [INST_WIDTH-1:0] inst_in,
   output logic                  full_out,
   output logic [PTR_WIDTH:0]    count_out,
   output logic [ADDR_WIDTH-1:0] pc_out,
   output logic [INST_WIDTH-1:0] inst_out,
   output logic                  valid_out
);

   localparam logic [PTR_WIDTH:0]   CNT_FULL = (PTR_WIDTH+1)'(DEPTH);
   localparam logic [PTR_WIDTH:0]   CNT_ONE  = (PTR_WIDTH+1)'(1);
   localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);

   logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
   logic [INST_WIDTH-1:0] inst_mem [DEPTH];

   logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_WIDTH:0]    count_q, count_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [INST_WIDTH-1:0] inst_q, inst_d;
   logic                  valid_q, valid_d;
   logic                  wr_en;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      pc_d     = pc_q;
      inst_d   = inst_q;
      valid_d  = valid_q;
      wr_en    = 1'b0;

      if (flush_in) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         pc_d     = '0;
         inst_d   = '0;
         valid_d  = 1'b0;
      end else if (stall_in) begin
         if (instE_in && (count_q != CNT_FULL)) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            count_d  = count_q + CNT_ONE;
         end
      end else if (count_q != '0) begin
         pc_d     = pc_mem[rd_ptr_q];
         inst_d   = inst_mem[rd_ptr_q];
         valid_d  = 1'b1;
         rd_ptr_d = rd_ptr_q + PTR_ONE;
         // The pop frees a slot this cycle, so a push is taken even at full;
         // at full wr_ptr equals rd_ptr and the head is read before the write.
         if (instE_in) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end else begin
            count_d  = count_q - CNT_ONE;
         end
      end else if (instE_in) begin
         pc_d    = pc_in;
         inst_d  = inst_in;
         valid_d = 1'b1;
      end else begin
         pc_d    = '0;
         inst_d  = '0;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         pc_q     <= '0;
         inst_q   <= '0;
         valid_q  <= 1'b0;
      end else if (rdy_in) begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         pc_q     <= pc_d;
         inst_q   <= inst_d;
         valid_q  <= valid_d;
      end
   end

   // Storage carries no reset; occupancy is tracked by count_q alone.
   always_ff @(posedge clk_in) begin
      if (rdy_in && wr_en) begin
         pc_mem[wr_ptr_q]   <= pc_in;
         inst_mem[wr_ptr_q] <= inst_in;
      end
   end

   assign full_out  = (count_q == CNT_FULL);
   assign count_out = count_q;
   assign pc_out    = pc_q;
   assign inst_out  = inst_q;
   assign valid_out = valid_q;

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;
   localparam int AW    = 32;
   localparam int IW    = 32;
   localparam int DEPTH = 4;
   localparam int PW    = 2;

   logic          clk_in   = 1'b0;
   logic          rst_in   = 1'b0;
   logic          rdy_in   = 1'b1;
   logic          flush_in = 1'b0;
   logic          stall_in = 1'b0;
   logic          instE_in = 1'b0;
   logic [AW-1:0] pc_in    = '0;
   logic [IW-1:0] inst_in  = '0;
   logic          full_out;
   logic [PW:0]   count_out;
   logic [AW-1:0] pc_out;
   logic [IW-1:0] inst_out;
   logic          valid_out;

   int checks = 0;
   int errors = 0;

   // Reference: a plain queue of {pc, inst} plus the expected output stage.
   logic [AW+IW-1:0] mq[$];
   logic [AW-1:0]    m_pc;
   logic [IW-1:0]    m_inst;
   logic             m_valid;

   if_id_queue #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .DEPTH(DEPTH), .PTR_WIDTH(PW)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
      .stall_in(stall_in), .instE_in(instE_in), .pc_in(pc_in), .inst_in(inst_in),
      .full_out(full_out), .count_out(count_out), .pc_out(pc_out),
      .inst_out(inst_out), .valid_out(valid_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_pc    = '0;
      m_inst  = '0;
      m_valid = 1'b0;
   endtask

   task automatic model_tick();
      logic [AW+IW-1:0] e;
      if (!rdy_in) return;
      if (flush_in) begin
         model_reset();
      end else if (stall_in) begin
         if (instE_in && mq.size() < DEPTH) mq.push_back({pc_in, inst_in});
      end else if (mq.size() > 0) begin
         e       = mq.pop_front();
         m_pc    = e[AW+IW-1:IW];
         m_inst  = e[IW-1:0];
         m_valid = 1'b1;
         if (instE_in) mq.push_back({pc_in, inst_in});
      end else if (instE_in) begin
         m_pc    = pc_in;
         m_inst  = inst_in;
         m_valid = 1'b1;
      end else begin
         m_pc    = '0;
         m_inst  = '0;
         m_valid = 1'b0;
      end
   endtask

   task automatic compare();
      chk("pc_out",    64'(pc_out),    64'(m_pc));
      chk("inst_out",  64'(inst_out),  64'(m_inst));
      chk("valid_out", 64'(valid_out), 64'(m_valid));
      chk("count_out", 64'(count_out), 64'(mq.size()));
      chk("full_out",  64'(full_out),  64'(mq.size() == DEPTH));
   endtask

   task automatic step();
      @(posedge clk_in);
      model_tick();
      #1;
      compare();
   endtask

   task automatic drive(input logic st, input logic en, input logic [AW-1:0] pc, input logic [IW-1:0] in);
      stall_in = st;
      instE_in = en;
      pc_in    = pc;
      inst_in  = in;
   endtask

   initial begin
      int pushed, seen, cyc;
      model_reset();
      repeat (2) @(posedge clk_in);
      #1;
      compare();
      chk("reset_valid", 64'(valid_out), 64'd0);
      chk("reset_count", 64'(count_out), 64'd0);
      rst_in = 1'b1;

      // bypass then bubble
      drive(1'b0, 1'b1, 32'h100, 32'h0000_0013);
      step();
      chk("bypass_pc",    64'(pc_out),    64'h100);
      chk("bypass_inst",  64'(inst_out),  64'h13);
      chk("bypass_valid", 64'(valid_out), 64'd1);
      chk("bypass_count", 64'(count_out), 64'd0);
      drive(1'b0, 1'b0, '0, '0);
      step();
      chk("bubble_valid", 64'(valid_out), 64'd0);
      chk("bubble_pc",    64'(pc_out),    64'd0);

      // fill under stall, drop fifth, drain
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 32'(4*i), 32'hA000 + 32'(i));
         step();
      end
      chk("fill_count", 64'(count_out), 64'd4);
      chk("fill_full",  64'(full_out),  64'd1);
      drive(1'b1, 1'b1, 32'h10, 32'hBAD);
      step();
      chk("drop_count", 64'(count_out), 64'd4);
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, '0, '0);
         step();
         chk("drain_pc", 64'(pc_out), 64'(4*i));
      end
      step();
      chk("drain_bubble", 64'(valid_out), 64'd0);

      // push and pop together at full
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 32'h200 + 32'(4*i), 32'(i));
         step();
      end
      drive(1'b0, 1'b1, 32'h20, 32'h2020);
      step();
      chk("pp_count", 64'(count_out), 64'd4);
      chk("pp_head",  64'(pc_out),    64'h200);
      drive(1'b0, 1'b0, '0, '0);
      repeat (4) step();
      chk("pp_last", 64'(pc_out), 64'h20);
      step();

      // flush with simultaneous push
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 32'h300 + 32'(4*i), 32'(i));
         step();
      end
      drive(1'b0, 1'b0, '0, '0);
      step();
      chk("pre_flush_count", 64'(count_out), 64'd3);
      flush_in = 1'b1;
      drive(1'b0, 1'b1, 32'h40, 32'h4040);
      step();
      flush_in = 1'b0;
      chk("flush_count", 64'(count_out), 64'd0);
      chk("flush_valid", 64'(valid_out), 64'd0);
      chk("flush_pc",    64'(pc_out),    64'd0);
      drive(1'b0, 1'b0, '0, '0);
      step();
      chk("flush_no_40", 64'(valid_out), 64'd0);

      // rdy freeze
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 32'h500 + 32'(4*i), 32'(i));
         step();
      end
      drive(1'b0, 1'b0, '0, '0);
      step();
      rdy_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 32'h600 + 32'(4*i), 32'(i));
         step();
         chk("freeze_count", 64'(count_out), 64'd2);
         chk("freeze_pc",    64'(pc_out),    64'h500);
      end
      rdy_in = 1'b1;
      drive(1'b0, 1'b0, '0, '0);
      step();
      chk("resume_pc1", 64'(pc_out), 64'h504);
      step();
      chk("resume_pc2", 64'(pc_out), 64'h508);
      step();

      // ten-instruction stream with random stalls, wrapping the pointers
      pushed = 0;
      seen   = 0;
      cyc    = 0;
      while ((pushed < 10 || seen < 10) && cyc < 300) begin
         stall_in = ($urandom_range(0, 2) == 0);
         instE_in = (pushed < 10) && (mq.size() < DEPTH) && ($urandom_range(0, 1) == 1);
         pc_in    = 32'h1000 + 32'(4*pushed);
         inst_in  = $urandom;
         step();
         if (instE_in) pushed++;
         if (!stall_in && valid_out) begin
            chk("stream_order", 64'(pc_out), 64'h1000 + 64'(4*seen));
            seen++;
         end
         cyc++;
      end
      chk("stream_done", 64'(seen), 64'd10);

      // random stress with an asynchronous reset between edges
      for (int i = 0; i < 1500; i++) begin
         rdy_in   = ($urandom_range(0, 9) != 0);
         flush_in = ($urandom_range(0, 19) == 0);
         stall_in = ($urandom_range(0, 9) < 3);
         instE_in = ($urandom_range(0, 9) < 6);
         pc_in    = $urandom;
         inst_in  = $urandom;
         step();
         if (i == 700) begin
            #2;
            rst_in = 1'b0;
            #1;
            chk("async_count", 64'(count_out), 64'd0);
            chk("async_valid", 64'(valid_out), 64'd0);
            chk("async_pc",    64'(pc_out),    64'd0);
            chk("async_inst",  64'(inst_out),  64'd0);
            model_reset();
            #1;
            rst_in = 1'b1;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end
endmodule
